// File: rtl/rdma_pkg.sv
// Shared types and constants for the RDMA remap scheduler.
package rdma_pkg;

    localparam int unsigned RDMA_ADDR_W = 32;

    // Offset the remap unit adds to a local address to form the remote address.
    localparam logic [RDMA_ADDR_W-1:0] RDMA_REMOTE_BASE = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request searching
// upward from last_grant+1 with wrap-around.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_idx
);

    logic            found;
    logic [ID_W-1:0] idx;

    // Scan NUM_REQ positions starting just after the previous winner.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int i = 1; i <= int'(NUM_REQ); i++) begin
            idx = ID_W'((int'(last_grant) + i) % int'(NUM_REQ));
            if (!found && req[idx]) begin
                found        = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = idx;
            end
        end
    end

endmodule

// File: rtl/rdma_remap_sched.sv
// Round-robin scheduler sharing one rdma_remap translation unit among NUM_REQ
// requesters; one transaction in flight at a time.
// Optional feature: define RDMA_REMAP_SCHED_CNT_EN to add per-requester 16-bit
// accept counters on output grant_cnt.
module rdma_remap_sched
    import rdma_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned ADDR_W    = RDMA_ADDR_W,
    parameter int unsigned REMAP_LAT = 1,
    localparam int unsigned ID_W     = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [ADDR_W-1:0]         remap_local_addr,
    input  logic [ADDR_W-1:0]         remap_remote_addr,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [ADDR_W-1:0]         rsp_addr
`ifdef RDMA_REMAP_SCHED_CNT_EN
    ,
    output logic [NUM_REQ*16-1:0]     grant_cnt
`endif
);

    localparam int unsigned CNT_W = (REMAP_LAT > 1) ? $clog2(REMAP_LAT) : 1;

    sched_state_t        state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ID_W-1:0]     last_grant_q, last_grant_d;
    logic [ADDR_W-1:0]   local_addr_q, local_addr_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
    logic [ADDR_W-1:0]   rsp_addr_q, rsp_addr_d;
    logic                rsp_valid_q, rsp_valid_d;

    logic [NUM_REQ-1:0]  arb_gnt;
    logic [ID_W-1:0]     arb_idx;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .gnt        (arb_gnt),
        .gnt_idx    (arb_idx)
    );

    // Next-state logic; req_ready depends only on state and req_valid.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        local_addr_d = local_addr_q;
        rsp_id_d     = rsp_id_q;
        rsp_addr_d   = rsp_addr_q;
        rsp_valid_d  = rsp_valid_q;
        req_ready    = '0;
        unique case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    req_ready    = arb_gnt;
                    local_addr_d = req_addr[arb_idx*ADDR_W +: ADDR_W];
                    rsp_id_d     = arb_idx;
                    last_grant_d = arb_idx;
                    cnt_d        = CNT_W'(REMAP_LAT - 1);
                    state_d      = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    rsp_addr_d  = remap_remote_addr;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, wait counter and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            local_addr_q <= '0;
            rsp_id_q     <= '0;
            rsp_addr_q   <= '0;
            rsp_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            local_addr_q <= local_addr_d;
            rsp_id_q     <= rsp_id_d;
            rsp_addr_q   <= rsp_addr_d;
            rsp_valid_q  <= rsp_valid_d;
        end
    end

    assign remap_local_addr = local_addr_q;
    assign rsp_valid        = rsp_valid_q;
    assign rsp_id           = rsp_id_q;
    assign rsp_addr         = rsp_addr_q;

`ifdef RDMA_REMAP_SCHED_CNT_EN
    logic [15:0] grant_cnt_q [NUM_REQ];

    // Count accepts per requester; 16-bit fields wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                grant_cnt_q[i] <= '0;
            end
        end else if (state_q == IDLE && |req_valid) begin
            grant_cnt_q[arb_idx] <= grant_cnt_q[arb_idx] + 16'd1;
        end
    end

    for (genvar g = 0; g < int'(NUM_REQ); g++) begin : g_cnt
        assign grant_cnt[g*16 +: 16] = grant_cnt_q[g];
    end
`endif

endmodule

// File: tb/tb_rdma_remap_sched.sv
// Directed self-checking bench for rdma_remap_sched (NUM_REQ=4, REMAP_LAT=1).
// The remap unit is modelled as local address + RDMA_REMOTE_BASE, available
// within the cycle after the local address registers.
module tb_rdma_remap_sched;
    import rdma_pkg::*;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [127:0] req_addr;
    logic [3:0]   req_ready;
    logic [31:0]  remap_local_addr;
    logic [31:0]  remap_remote_addr;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_addr;
`ifdef RDMA_REMAP_SCHED_CNT_EN
    logic [63:0]  grant_cnt;
`endif

    int errs   = 0;
    int checks = 0;

    rdma_remap_sched #(
        .NUM_REQ   (4),
        .ADDR_W    (32),
        .REMAP_LAT (1)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_valid         (req_valid),
        .req_addr          (req_addr),
        .req_ready         (req_ready),
        .remap_local_addr  (remap_local_addr),
        .remap_remote_addr (remap_remote_addr),
        .rsp_valid         (rsp_valid),
        .rsp_ready         (rsp_ready),
        .rsp_id            (rsp_id),
        .rsp_addr          (rsp_addr)
`ifdef RDMA_REMAP_SCHED_CNT_EN
        ,
        .grant_cnt         (grant_cnt)
`endif
    );

    assign remap_remote_addr = remap_local_addr + RDMA_REMOTE_BASE;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge with requests already driven; ends at a negedge in IDLE.
    task automatic txn(input string tag, input int id, input logic [31:0] la,
                       input logic [31:0] ra, input int hold);
        logic [3:0] oh;
        oh = 4'b0001 << id;
        rsp_ready = (hold == 0);
        #1;
        check({tag, ".gnt"}, 64'(req_ready), 64'(oh));
        @(negedge clk);
        check({tag, ".lcl"}, 64'(remap_local_addr), 64'(la));
        check({tag, ".wait_rdy"}, 64'(req_ready), 64'd0);
        check({tag, ".wait_vld"}, 64'(rsp_valid), 64'd0);
        @(negedge clk);
        check({tag, ".vld"}, 64'(rsp_valid), 64'd1);
        check({tag, ".id"}, 64'(rsp_id), 64'(id));
        check({tag, ".addr"}, 64'(rsp_addr), 64'(ra));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, ".hold_vld"}, 64'(rsp_valid), 64'd1);
            check({tag, ".hold_id"}, 64'(rsp_id), 64'(id));
            check({tag, ".hold_addr"}, 64'(rsp_addr), 64'(ra));
            check({tag, ".hold_rdy"}, 64'(req_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check({tag, ".done"}, 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst.req_ready", 64'(req_ready), 64'd0);
        check("rst.local", 64'(remap_local_addr), 64'd0);
        check("rst.rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst.rsp_id", 64'(rsp_id), 64'd0);
        check("rst.rsp_addr", 64'(rsp_addr), 64'd0);
        rst_n = 1'b1;

        // Requester 0 right after reset release.
        req_valid = 4'b0001;
        req_addr[0*32 +: 32] = 32'h0000_1000;
        txn("r0", 0, 32'h0000_1000, 32'h8000_1000, 0);
        req_valid = '0;

        // Requester 2; translation wraps past 2^32.
        req_valid = 4'b0100;
        req_addr[2*32 +: 32] = 32'hFFFF_0000;
        txn("r2", 2, 32'hFFFF_0000, 32'h7FFF_0000, 0);
        req_valid = '0;

        // Backpressure: rsp_ready low while in RESP.
        req_valid = 4'b0010;
        req_addr[1*32 +: 32] = 32'h1234_5678;
        txn("bp", 1, 32'h1234_5678, 32'h9234_5678, 5);
        req_valid = '0;

        // Reset while the transaction sits in WAIT.
        req_valid = 4'b1000;
        req_addr[3*32 +: 32] = 32'h0000_0040;
        rsp_ready = 1'b1;
        #1;
        check("ab.gnt", 64'(req_ready), 64'b1000);
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '0;
        #1;
        check("ab.req_ready", 64'(req_ready), 64'd0);
        check("ab.local", 64'(remap_local_addr), 64'd0);
        check("ab.rsp_valid", 64'(rsp_valid), 64'd0);
        check("ab.rsp_id", 64'(rsp_id), 64'd0);
        check("ab.rsp_addr", 64'(rsp_addr), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("ab.stale", 64'(rsp_valid), 64'd0);
        end

        // All four requesting: round robin from requester 0.
        req_valid = 4'b1111;
        req_addr  = {32'h0000_0400, 32'h0000_0300, 32'h0000_0200, 32'h0000_0100};
        txn("rr0", 0, 32'h0000_0100, 32'h8000_0100, 0);
        txn("rr1", 1, 32'h0000_0200, 32'h8000_0200, 0);
        txn("rr2", 2, 32'h0000_0300, 32'h8000_0300, 0);
        txn("rr3", 3, 32'h0000_0400, 32'h8000_0400, 0);
        txn("rr4", 0, 32'h0000_0100, 32'h8000_0100, 0);
        req_valid = '0;

`ifdef RDMA_REMAP_SCHED_CNT_EN
        check("cnt", grant_cnt, {16'd1, 16'd1, 16'd1, 16'd2});
`endif

        @(negedge clk);
        check("end.idle", 64'(req_ready), 64'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
